grf_scoreboard: RTL and testbench

Tracks register writes already issued down the five-stage pipeline and compares them with the source registers of the instruction in D. From that it produces the D-stage stall and the D-stage bypass selects for the general register file. It sits beside the register file in the decode stage and is the only block allowed to stall the front end for data hazards. Write-back-stage results are bypassed inside the register file, so this block forwards only from the E and M stages.

---
 rtl/grf_scoreboard_if.sv | 41 ++++
 rtl/grf_scoreboard.sv | 113 +++++++++++
 tb/tb_grf_scoreboard.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/grf_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : grf_scoreboard_if
//  Description : Decode-stage hazard interface between the D-stage control
//                (master) and the GRF scoreboard (slave).
//                master drives : issue_we, issue_rd, issue_tnew,
//                                rs_used, rs_addr, rs_tuse,
//                                rt_used, rt_addr, rt_tuse
//                slave drives  : stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface grf_scoreboard_if;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_tnew;
  logic        rs_used;
  logic [4:0]  rs_addr;
  logic [1:0]  rs_tuse;
  logic        rt_used;
  logic [4:0]  rt_addr;
  logic [1:0]  rt_tuse;
  logic        stall;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic [31:0] stall_cnt;

  modport master (
    output issue_we, issue_rd, issue_tnew,
    output rs_used, rs_addr, rs_tuse,
    output rt_used, rt_addr, rt_tuse,
    input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );

  modport slave (
    input  issue_we, issue_rd, issue_tnew,
    input  rs_used, rs_addr, rs_tuse,
    input  rt_used, rt_addr, rt_tuse,
    output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/grf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : grf_scoreboard
//  Description : Tracks register writes in flight in E, M and W and compares
//                them with the D-stage source registers. Produces the D-stage
//                stall and the E/M bypass selects for rs and rt. W-stage
//                results are bypassed inside the register file itself.
//  Ports       : clk    - clock
//                reset  - synchronous, active-high reset
//                sb     - grf_scoreboard_if.slave
//                         in : issue_we/rd/tnew, rs_used/addr/tuse,
//                              rt_used/addr/tuse
//                         out: stall, fwd_rs_sel, fwd_rt_sel (0 GRF, 1 E,
//                              2 M), stall_cnt (stalled cycles since reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_scoreboard (
  input  wire logic         clk,
  input  wire logic         reset,
  grf_scoreboard_if.slave   sb
);

  localparam logic [1:0] c_SEL_GRF = 2'd0;
  localparam logic [1:0] c_SEL_E   = 2'd1;
  localparam logic [1:0] c_SEL_M   = 2'd2;

  // In-flight slots: {valid, rd, tnew} for E, M, W
  logic        r_e_valid, r_m_valid, r_w_valid;
  logic [4:0]  r_e_rd,    r_m_rd,    r_w_rd;
  logic [1:0]  r_e_tnew,  r_m_tnew,  r_w_tnew;
  logic [31:0] r_stall_cnt;

  logic [2:0]  w_rs_res;
  logic [2:0]  w_rt_res;
  logic        w_stall;

  // Resolve one source against the slots. Returns {stall, fwd_sel}.
  // Only the youngest matching slot is considered (E > M > W).
  function automatic logic [2:0] f_resolve(
    input logic       used,
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic       e_v, input logic [4:0] e_rd, input logic [1:0] e_tn,
    input logic       m_v, input logic [4:0] m_rd, input logic [1:0] m_tn,
    input logic       w_v, input logic [4:0] w_rd, input logic [1:0] w_tn
  );
    logic       live;
    logic [2:0] res;
    live = used && (addr != 5'd0);
    res  = {1'b0, c_SEL_GRF};
    if (live && e_v && (e_rd == addr)) begin
      res = {(e_tn > tuse), (e_tn == 2'd0) ? c_SEL_E : c_SEL_GRF};
    end else if (live && m_v && (m_rd == addr)) begin
      res = {(m_tn > tuse), (m_tn == 2'd0) ? c_SEL_M : c_SEL_GRF};
    end else if (live && w_v && (w_rd == addr)) begin
      // Value is read through the register file's internal bypass.
      res = {(w_tn > tuse), c_SEL_GRF};
    end
    return res;
  endfunction

  always_comb begin
    w_rs_res = f_resolve(sb.rs_used, sb.rs_addr, sb.rs_tuse,
                         r_e_valid, r_e_rd, r_e_tnew,
                         r_m_valid, r_m_rd, r_m_tnew,
                         r_w_valid, r_w_rd, r_w_tnew);
    w_rt_res = f_resolve(sb.rt_used, sb.rt_addr, sb.rt_tuse,
                         r_e_valid, r_e_rd, r_e_tnew,
                         r_m_valid, r_m_rd, r_m_tnew,
                         r_w_valid, r_w_rd, r_w_tnew);
    w_stall  = w_rs_res[2] | w_rt_res[2];
  end

  assign sb.stall      = w_stall;
  assign sb.fwd_rs_sel = w_rs_res[1:0];
  assign sb.fwd_rt_sel = w_rt_res[1:0];
  assign sb.stall_cnt  = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_valid   <= 1'b0;
      r_e_rd      <= 5'd0;
      r_e_tnew    <= 2'd0;
      r_m_valid   <= 1'b0;
      r_m_rd      <= 5'd0;
      r_m_tnew    <= 2'd0;
      r_w_valid   <= 1'b0;
      r_w_rd      <= 5'd0;
      r_w_tnew    <= 2'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_w_valid <= r_m_valid;
      r_w_rd    <= r_m_rd;
      r_w_tnew  <= 2'd0;

      r_m_valid <= r_e_valid;
      r_m_rd    <= r_e_rd;
      r_m_tnew  <= (r_e_tnew == 2'd0) ? 2'd0 : (r_e_tnew - 2'd1);

      // A stalled D instruction enters E as a bubble; writes to $0 are
      // never recorded.
      r_e_valid <= sb.issue_we && (sb.issue_rd != 5'd0) && !w_stall;
      r_e_rd    <= sb.issue_rd;
      r_e_tnew  <= sb.issue_tnew;

      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_scoreboard
//  Description : Self-checking bench for grf_scoreboard. A history model
//                keeps the last three issued writes indexed by age and
//                derives each write's remaining latency from its age.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_scoreboard;

  logic clk;
  logic reset;

  grf_scoreboard_if sb ();

  grf_scoreboard u_dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] tnew;
  } wr_t;

  // hist[age]: age 0 entered E at the last edge, 1 is one edge older, ...
  wr_t         hist [3];
  logic [31:0] m_cnt;
  int          n_tests;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference resolution from the age history: a write's result exists once
  // its age has caught up with its tnew; W (age 2) is read from the GRF.
  task automatic model_resolve(input logic used, input logic [4:0] addr, input logic [1:0] tuse,
                               output logic st, output logic [1:0] sel);
    bit found;
    int rem;
    st    = 1'b0;
    sel   = 2'd0;
    found = 0;
    if (used && addr != 5'd0) begin
      for (int age = 0; age < 3; age++) begin
        if (!found && hist[age].valid && hist[age].rd == addr) begin
          found = 1;
          rem   = (int'(hist[age].tnew) > age) ? int'(hist[age].tnew) - age : 0;
          st    = (rem > int'(tuse));
          if (rem == 0 && age < 2) sel = 2'(age + 1);
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 5'd0, 2'd0};
    m_cnt = 32'd0;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] tn,
                       input logic rsu, input logic [4:0] rsa, input logic [1:0] rsut,
                       input logic rtu, input logic [4:0] rta, input logic [1:0] rtut);
    sb.issue_we   = we;
    sb.issue_rd   = rd;
    sb.issue_tnew = tn;
    sb.rs_used    = rsu;
    sb.rs_addr    = rsa;
    sb.rs_tuse    = rsut;
    sb.rt_used    = rtu;
    sb.rt_addr    = rta;
    sb.rt_tuse    = rtut;
  endtask

  // Compare all outputs against the model mid-cycle, then advance one edge.
  task automatic tick();
    logic       s_rs, s_rt, s_exp;
    logic [1:0] f_rs, f_rt;
    @(negedge clk);
    model_resolve(sb.rs_used, sb.rs_addr, sb.rs_tuse, s_rs, f_rs);
    model_resolve(sb.rt_used, sb.rt_addr, sb.rt_tuse, s_rt, f_rt);
    s_exp = s_rs | s_rt;
    check_eq("stall",      32'(sb.stall),      32'(s_exp));
    check_eq("fwd_rs_sel", 32'(sb.fwd_rs_sel), 32'(f_rs));
    check_eq("fwd_rt_sel", 32'(sb.fwd_rt_sel), 32'(f_rt));
    check_eq("stall_cnt",  sb.stall_cnt,       m_cnt);
    if (reset) begin
      model_clear();
    end else begin
      if (s_exp) m_cnt = m_cnt + 32'd1;
      hist[2] = '{hist[1].valid, hist[1].rd, hist[1].tnew};
      hist[1] = '{hist[0].valid, hist[0].rd, hist[0].tnew};
      hist[0] = '{sb.issue_we && sb.issue_rd != 5'd0 && !s_exp, sb.issue_rd, sb.issue_tnew};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_clear();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd5, 2'd0, 1'b0, 5'd0, 2'd0);
    settle();
    check_eq("rst_stall", 32'(sb.stall), 32'd0);
    check_eq("rst_fwd",   32'(sb.fwd_rs_sel), 32'd0);
    check_eq("rst_cnt",   sb.stall_cnt, 32'd0);
    tick();

    // Load-use: one stall; afterwards the load sits in M with tnew 1, which
    // is not yet forwardable, so the select stays on the GRF.
    do_reset();
    drive(1'b1, 5'd8, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd8, 2'd1, 1'b0, 5'd0, 2'd0);
    settle(); check_eq("lu_stall1", 32'(sb.stall), 32'd1); tick();
    settle(); check_eq("lu_stall2", 32'(sb.stall), 32'd0);
    check_eq("lu_fwd", 32'(sb.fwd_rs_sel), 32'd0);
    check_eq("lu_cnt", sb.stall_cnt, 32'd1); tick();

    // Load then branch: two stalls
    do_reset();
    drive(1'b1, 5'd9, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd9, 2'd0);
    settle(); check_eq("lb_stall1", 32'(sb.stall), 32'd1); tick();
    settle(); check_eq("lb_stall2", 32'(sb.stall), 32'd1); tick();
    settle(); check_eq("lb_stall3", 32'(sb.stall), 32'd0);
    check_eq("lb_fwd", 32'(sb.fwd_rt_sel), 32'd0);
    check_eq("lb_cnt", sb.stall_cnt, 32'd2); tick();

    // ALU back-to-back, tuse 1: deferred forwarding
    do_reset();
    drive(1'b1, 5'd3, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd3, 2'd1, 1'b0, 5'd0, 2'd0);
    settle(); check_eq("alu1_stall", 32'(sb.stall), 32'd0);
    check_eq("alu1_fwd", 32'(sb.fwd_rs_sel), 32'd0); tick();

    // ALU back-to-back, tuse 0: one stall then forward from M
    do_reset();
    drive(1'b1, 5'd3, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd3, 2'd0, 1'b0, 5'd0, 2'd0);
    settle(); check_eq("alu0_stall1", 32'(sb.stall), 32'd1); tick();
    settle(); check_eq("alu0_stall2", 32'(sb.stall), 32'd0);
    check_eq("alu0_fwd", 32'(sb.fwd_rs_sel), 32'd2); tick();

    // Youngest wins
    do_reset();
    drive(1'b1, 5'd4, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick(); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd4, 2'd1, 1'b0, 5'd0, 2'd0);
    settle(); check_eq("yw_fwd", 32'(sb.fwd_rs_sel), 32'd1);
    check_eq("yw_stall", 32'(sb.stall), 32'd0); tick();

    // $0 is never tracked
    do_reset();
    drive(1'b1, 5'd0, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    settle(); check_eq("r0_stall", 32'(sb.stall), 32'd0);
    check_eq("r0_fwd", 32'(sb.fwd_rs_sel), 32'd0); tick();

    // W bypass through the GRF
    do_reset();
    drive(1'b1, 5'd6, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick();
    idle(); tick(); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd6, 2'd0);
    settle(); check_eq("w_stall", 32'(sb.stall), 32'd0);
    check_eq("w_fwd", 32'(sb.fwd_rt_sel), 32'd0); tick();

    // One slot matching both sources: stall is the OR
    do_reset();
    drive(1'b1, 5'd7, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd7, 2'd2, 1'b1, 5'd7, 2'd0);
    settle(); check_eq("both_stall", 32'(sb.stall), 32'd1); tick();

    // Reset while a hazard is active drops the stall and the pending write
    do_reset();
    drive(1'b1, 5'd8, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0); tick();
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd8, 2'd0, 1'b0, 5'd0, 2'd0);
    settle(); check_eq("rh_stall1", 32'(sb.stall), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    settle(); check_eq("rh_stall2", 32'(sb.stall), 32'd0);
    check_eq("rh_cnt", sb.stall_cnt, 32'd0); tick();

    // Randomized traffic on a narrow register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(99) == 0);
      drive(1'($urandom_range(1)), 5'($urandom_range(3)), 2'($urandom_range(2)),
            1'($urandom_range(1)), 5'($urandom_range(3)), 2'($urandom_range(2)),
            1'($urandom_range(1)), 5'($urandom_range(3)), 2'($urandom_range(2)));
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
